// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: fetch states,
// instruction field positions, default reset PC and a field-splitting helper.
`default_nettype none

package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IF_S_START = 2'd0,
    IF_S_REQ   = 2'd1,
    IF_S_WAIT  = 2'd2,
    IF_S_ISSUE = 2'd3
  } if_state_e;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int JADDR_HI  = 25;
  localparam int JADDR_LO  = 0;

  localparam logic [31:0] IF_DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  funct;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input logic [31:0] word);
    instr_fields_t f;
    f.opcode = word[OPCODE_HI:OPCODE_LO];
    f.rs     = word[RS_HI:RS_LO];
    f.rt     = word[RT_HI:RT_LO];
    f.rd     = word[RD_HI:RD_LO];
    f.imm    = word[IMM_HI:IMM_LO];
    f.funct  = word[FUNCT_HI:FUNCT_LO];
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_next_pc_calc.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
`default_nettype none

module next_pc_calc
  import instr_fetch_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic [31:0]         instr,
  input  logic                branch,
  input  logic                zero,
  input  logic                jump,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0] branch_target;
  logic                unused_opcode;

  // Jump keeps the 256 MB region of the sequential address.
  assign jump_target   = {pc_plus4[PC_WIDTH-1:28], instr[JADDR_HI:JADDR_LO], 2'b00};
  assign branch_offset = {{(PC_WIDTH-18){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign unused_opcode = ^instr[OPCODE_HI:OPCODE_LO];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory and presents it to the decoder with valid/ready.
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                 PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(IF_DEFAULT_RESET_PC),
  parameter int                 CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [15:0]          imm,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus4,
  input  logic                 branch,
  input  logic                 zero,
  input  logic                 jump,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  if_state_e           state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         instr_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                imem_req_q;
  logic                instr_valid_q;
  logic [PC_WIDTH-1:0] pc_plus4_w;
  logic [PC_WIDTH-1:0] next_pc_d;
  logic                accept;
  instr_fields_t       fields;

  assign pc_plus4_w = pc_q + PC_WIDTH'(4);
  assign accept     = instr_valid_q && instr_ready;

  next_pc_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc_calc (
    .pc_plus4 (pc_plus4_w),
    .instr    (instr_q),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (next_pc_d)
  );

  // Outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IF_S_START;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= 32'h0;
      retired_q     <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IF_S_START: begin
          state_q    <= IF_S_REQ;
          imem_req_q <= 1'b1;
        end
        IF_S_REQ: begin
          state_q    <= IF_S_WAIT;
          imem_req_q <= 1'b0;
        end
        IF_S_WAIT: begin
          if (imem_rvalid) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= IF_S_ISSUE;
          end
        end
        IF_S_ISSUE: begin
          if (accept) begin
            pc_q          <= next_pc_d;
            retired_q     <= retired_q + CNT_WIDTH'(1);
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= IF_S_REQ;
          end
        end
        default: begin
          state_q       <= IF_S_START;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fields      = split_fields(instr_q);
  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = fields.opcode;
  assign funct       = fields.funct;
  assign rs          = fields.rs;
  assign rt          = fields.rt;
  assign rd          = fields.rd;
  assign imm         = fields.imm;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign retired     = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed corner cases followed by
// randomized fetch traffic checked against a PC-level reference model.
`default_nettype none

module tb_instr_fetch;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          branch, zero, jump;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  instr_fetch #(
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .retired     (retired)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;
  int          exp_ret;
  int          exp_gap;
  int          last_req;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic z, input logic j);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'($signed(w[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_eq("req_timeout", 32'(imem_req), 32'd1);
    else     check_eq("req_addr", imem_addr, exp_pc);
  endtask

  task automatic release_reset();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_eq("start_rvalid_ignored", instr, 32'd0);
    imem_rvalid = 1'b0;
    exp_pc  = 32'h0;
    exp_ret = 0;
    exp_gap = 0;
  endtask

  task automatic run_instr(input logic [31:0] w, input int lat, input int rdly,
                           input logic b, input logic z, input logic j, input bit spur);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    if (exp_gap > 0) check_eq("req_gap", 32'(cyc - last_req), 32'(exp_gap));
    last_req = cyc;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check_eq("req_in_wait", 32'(imem_req), 32'd0);
      check_eq("valid_in_wait", 32'(instr_valid), 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check_eq("valid", 32'(instr_valid), 32'd1);
    check_eq("instr", instr, w);
    check_eq("pc", pc, exp_pc);
    check_eq("pc_plus4", pc_plus4, exp_pc + 32'd4);
    check_eq("opcode", 32'(opcode), 32'(w[31:26]));
    check_eq("funct", 32'(funct), 32'(w[5:0]));
    check_eq("rs", 32'(rs), 32'(w[25:21]));
    check_eq("rt", 32'(rt), 32'(w[20:16]));
    check_eq("rd", 32'(rd), 32'(w[15:11]));
    check_eq("imm", 32'(imm), 32'(w[15:0]));
    for (int k = 0; k < rdly; k++) begin
      instr_ready = 1'b0;
      {branch, zero, jump} = 3'($urandom);
      if (spur) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      check_eq("hold_instr", instr, w);
      check_eq("hold_pc", pc, exp_pc);
      check_eq("hold_req", 32'(imem_req), 32'd0);
      check_eq("hold_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    branch = b;
    zero   = z;
    jump   = j;
    @(negedge clk);
    instr_ready = 1'b0;
    {branch, zero, jump} = 3'($urandom);
    exp_pc  = model_next(exp_pc, w, b, z, j);
    exp_ret = exp_ret + 1;
    check_eq("retired", 32'(retired), 32'(exp_ret % (1 << CW)));
    check_eq("valid_after_accept", 32'(instr_valid), 32'd0);
    exp_gap = lat + rdly + 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
    jump   = 1'b0;
    exp_pc = 32'h0;
    exp_ret = 0;
    exp_gap = 0;
    last_req = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    release_reset();

    // Sequential fetches with a one-cycle memory.
    run_instr(32'h2001_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h0123_4567, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h8C22_0004, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("retired_3", 32'(retired), 32'd3);

    // Asynchronous reset while waiting for memory.
    wait_req(ok);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(instr_valid), 32'd0);
    check_eq("async_pc", pc, 32'h0);
    check_eq("async_instr", instr, 32'd0);
    check_eq("async_retired", 32'(retired), 32'd0);
    check_eq("async_req", 32'(imem_req), 32'd0);
    release_reset();

    // Jumps, branches and PC wrap-around.
    run_instr(32'h0800_0010, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // 0x0 -> 0x40
    run_instr(32'h1000_FFED, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0);  // 0x40 -> 0xFFFFFFF8
    run_instr(32'h0800_0000, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // -> 0xF0000000
    run_instr(32'h0800_0010, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // -> 0xF0000040
    run_instr(32'h0BFF_FFFF, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // -> 0xFFFFFFFC
    run_instr(32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // fall-through -> 0x0
    run_instr(32'h0800_0008, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // -> 0x20
    run_instr(32'h1000_FFFE, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0);  // taken -> 0x1C
    run_instr(32'h0800_0008, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // -> 0x20
    run_instr(32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // not taken -> 0x24
    run_instr(32'h0085_1020, 5, 4, 1'b0, 1'b0, 1'b0, 1'b1);  // slow memory, stalls
    run_instr(32'h1000_0003, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0);  // jump wins over branch

    for (int i = 0; i < 200; i++) begin
      logic [31:0] w;
      logic        b, z, j;
      w = $urandom;
      b = 1'($urandom);
      z = 1'($urandom);
      j = ($urandom_range(0, 3) == 0);
      run_instr(w, $urandom_range(1, 4), $urandom_range(0, 3), b, z, j, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
